// File: rtl/cache_pkg.sv
// Shared cache definitions: block geometry and the fill engine state encoding.
package cache_pkg;

  localparam int BLOCK_OFFSET_BITS   = 4;
  localparam int DEF_WORDS_PER_BLOCK = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// 4-bit counter with synchronous clear, increment enable and saturation at limit.
module fill_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] limit,
  output logic [3:0] cnt
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Clear wins over increment; increment stops once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/full_adder_16bit.sv
// Plain binary adder used for block-relative address generation; carry-out is
// dropped so results wrap modulo 2^W.
module full_adder_16bit #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: on a miss, issues one main-memory read per cycle for
// every word of the block, writes each returning word into the data array, and
// writes the tag alongside the final word. fsm_busy stalls the CPU meanwhile.
//
// Memory return interface: memory_data_valid is a one-cycle qualifier with no
// back-pressure; the engine must accept the word in the very cycle it is
// valid. Words return in issue order, so counting valids identifies the word.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        data_word_sel,
  output logic [DATA_W-1:0] write_data,
  output logic              write_tag_array
);

  localparam logic [3:0] WPB       = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK =
    {{(ADDR_W-BLOCK_OFFSET_BITS){1'b1}}, {BLOCK_OFFSET_BITS{1'b0}}};

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_addr_q, base_addr_d;
  logic [3:0]        issue_cnt;
  logic [3:0]        recv_cnt;
  logic [ADDR_W-1:0] issue_addr;
  logic              in_fill;
  logic              issuing;
  logic              last_word;

  assign in_fill   = (state_q == FILL);
  assign issuing   = in_fill && (issue_cnt < WPB);
  assign last_word = in_fill && memory_data_valid && (recv_cnt == LAST_WORD);

  // Both counters are held at zero while idle, so each fill starts from word 0.
  fill_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_fill),
    .inc   (issuing),
    .limit (WPB),
    .cnt   (issue_cnt)
  );

  fill_counter u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_fill),
    .inc   (in_fill && memory_data_valid),
    .limit (LAST_WORD),
    .cnt   (recv_cnt)
  );

  // Word offset is added to the aligned base; the base has zero low bits, so
  // the offset never carries into the block index.
  full_adder_16bit #(.W(ADDR_W)) u_addr_add (
    .a   (base_addr_q),
    .b   ({{(ADDR_W-5){1'b0}}, issue_cnt, 1'b0}),
    .sum (issue_addr)
  );

  // Next-state: start a fill on a miss seen while idle, finish on the last word.
  always_comb begin
    state_d     = state_q;
    base_addr_d = base_addr_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_addr_d = miss_address & BASE_MASK;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (last_word) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and base address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      base_addr_q <= base_addr_d;
    end
  end

  // Outputs: all zero while idle; during a fill the receive side is a direct
  // pass-through of the memory return qualified by the word count.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_sel    = 3'd0;
    write_data       = '0;
    write_tag_array  = 1'b0;
    if (in_fill) begin
      fsm_busy         = 1'b1;
      mem_read_en      = issuing;
      memory_address   = issuing ? issue_addr : base_addr_q;
      write_data_array = memory_data_valid;
      data_word_sel    = recv_cnt[2:0];
      write_data       = memory_data;
      write_tag_array  = last_word;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency pipelined memory model
// and a fill-level reference model checked every cycle.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_word_sel;
  logic [15:0] write_data;
  logic        write_tag_array;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_word_sel     (data_word_sel),
    .write_data        (write_data),
    .write_tag_array   (write_tag_array)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 4;
  bit chk_en = 0;
  bit noise_en = 0;

  // Memory request history, indexed by cycle number.
  bit          rd_v[64];
  logic [15:0] rd_a[64];

  // Reference model: a fill is (start cycle, block base); everything else follows.
  bit          m_active = 0;
  int          m_fs = 0;
  logic [15:0] m_base = '0;

  // Per-fill observations for literal checks.
  int          st_busy, st_tag, st_tag_rel, st_first_busy;
  bit          st_seen_rd;
  logic [15:0] st_first, st_last;
  int          sel_log[$];

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) rd_v[i] = 1'b0;
  endtask

  task automatic clear_stats();
    st_busy = 0; st_tag = 0; st_tag_rel = -1; st_first_busy = 0;
    st_seen_rd = 0; st_first = '0; st_last = '0;
    sel_log.delete();
  endtask

  // One clock: update the model from inputs sampled at the edge, then drive
  // the memory return for the new cycle.
  task automatic tick();
    int slot;
    @(posedge clk);
    if (rst) begin
      m_active = 0;
      clear_mem();
    end else if (m_active && (cyc - m_fs) == lat + 7) begin
      m_active = 0;
    end else if (!m_active && miss_detected) begin
      m_active = 1;
      m_fs     = cyc + 1;
      m_base   = miss_address & 16'hFFF0;
    end
    cyc++;
    #1;
    slot = (cyc - lat) % 64;
    if (cyc >= lat && rd_v[slot]) begin
      memory_data_valid = 1'b1;
      memory_data       = memfn(rd_a[slot]);
    end else begin
      memory_data_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      memory_data       = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && fsm_busy; i++) tick();
    chk("idle_timeout", int'(fsm_busy), 0);
  endtask

  task automatic check_fill(input logic [15:0] first, input logic [15:0] last,
                            input int busy, input int tag_rel);
    chk("first_addr", st_first, first);
    chk("last_addr", st_last, last);
    chk("busy_cycles", st_busy, busy);
    chk("tag_count", st_tag, 1);
    chk("tag_cycle", st_tag_rel, tag_rel);
    chk("sel_count", sel_log.size(), 8);
    for (int i = 0; i < sel_log.size() && i < 8; i++) chk("sel_order", sel_log[i], i);
  endtask

  task automatic run_fill(input logic [15:0] addr);
    clear_stats();
    miss_detected = 1'b1;
    miss_address  = addr;
    tick();
    miss_detected = 1'b0;
    wait_idle(40);
  endtask

  // Per-cycle compare against the model, plus memory request capture.
  always @(negedge clk) begin
    int rel;
    bit e_rd, e_wr;
    logic [15:0] e_addr;
    int e_sel;
    rd_v[cyc % 64] = mem_read_en;
    rd_a[cyc % 64] = memory_address;
    if (chk_en) begin
      if (m_active) begin
        rel    = cyc - m_fs;
        e_rd   = (rel < 8);
        e_addr = e_rd ? m_base + 16'(2 * rel) : m_base;
        e_wr   = (rel >= lat) && (rel < lat + 8);
        e_sel  = (rel < lat) ? 0 : rel - lat;
        chk("busy", int'(fsm_busy), 1);
        chk("rd_en", int'(mem_read_en), int'(e_rd));
        chk("addr", memory_address, e_addr);
        chk("mem_valid", int'(memory_data_valid), int'(e_wr));
        chk("wr", int'(write_data_array), int'(memory_data_valid));
        chk("sel", data_word_sel, e_sel);
        chk("tag", int'(write_tag_array), int'(rel == lat + 7));
        chk("wdata", write_data, memory_data);
        if (e_wr) chk("rdata", write_data, memfn(m_base + 16'(2 * (rel - lat))));
      end else begin
        chk("busy", int'(fsm_busy), 0);
        chk("rd_en", int'(mem_read_en), 0);
        chk("addr", memory_address, 0);
        chk("wr", int'(write_data_array), 0);
        chk("sel", data_word_sel, 0);
        chk("tag", int'(write_tag_array), 0);
        chk("wdata", write_data, 0);
      end
    end
    if (fsm_busy) begin
      if (st_busy == 0) st_first_busy = cyc;
      st_busy++;
    end
    if (mem_read_en) begin
      if (!st_seen_rd) st_first = memory_address;
      st_seen_rd = 1;
      st_last    = memory_address;
    end
    if (write_tag_array) begin
      st_tag++;
      st_tag_rel = cyc - st_first_busy;
    end
    if (write_data_array) sel_log.push_back(int'(data_word_sel));
  end

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data_valid = 1'b0;
    memory_data = '0;
    clear_mem();
    clear_stats();
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1;
    // Reset state.
    chk("reset_busy", int'(fsm_busy), 0);
    chk("reset_rd_en", int'(mem_read_en), 0);
    tick();

    // Basic fill, latency 4, unaligned odd-word address.
    lat = 4;
    run_fill(16'h1236);
    check_fill(16'h1230, 16'h123E, 12, 11);
    tick();

    // Wrap boundary at the top of the address space.
    run_fill(16'hFFFF);
    check_fill(16'hFFF0, 16'hFFFE, 12, 11);
    tick();

    // Miss held through a fill, including the completing cycle.
    clear_stats();
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    tick();
    miss_address  = 16'h4000;
    wait_idle(40);
    check_fill(16'h1230, 16'h123E, 12, 11);
    clear_stats();
    tick();
    miss_detected = 1'b0;
    wait_idle(40);
    check_fill(16'h4000, 16'h400E, 12, 11);
    tick();

    // Reset in cycle 6 of a fill aborts it without a tag write.
    clear_stats();
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    tick();
    miss_detected = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(fsm_busy), 0);
    chk("abort_tag", int'(write_tag_array), 0);
    chk("abort_rd_en", int'(mem_read_en), 0);
    repeat (3) tick();
    chk("abort_tag_count", st_tag, 0);
    run_fill(16'h2000);
    check_fill(16'h2000, 16'h200E, 12, 11);
    tick();

    // Latency sweep.
    lat = 1;
    clear_mem();
    run_fill(16'h3458);
    check_fill(16'h3450, 16'h345E, 9, 8);
    tick();
    lat = 7;
    clear_mem();
    run_fill(16'h0A0F);
    check_fill(16'h0A00, 16'h0A0E, 15, 14);
    tick();

    // Stray valids while idle must be ignored.
    lat = 4;
    clear_mem();
    clear_stats();
    noise_en = 1;
    repeat (12) tick();
    noise_en = 0;
    tick();
    chk("noise_busy", st_busy, 0);
    chk("noise_writes", sel_log.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling engine that sits directly downstream of the CPU's instruction and data memory ports.
- When the cache (I or D) flags a miss, it fetches the whole 16-byte block (8 words) from the multi-cycle main memory (memory4c, pipelined, fixed latency).
- It streams each returning word into the cache data array and writes the tag once the last word lands.
- fsm_busy stalls the pipeline for the duration of the fill.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; power of 2, 2..8.
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- miss_detected  input  1  cache miss this cycle; sampled only in IDLE.
- miss_address  input  ADDR_W  byte address that missed.
- memory_data_valid  input  1  main memory returns a word this cycle.
- memory_data  input  DATA_W  returned word; passed through unchanged.
- fsm_busy  output  1  fill in progress; CPU stall.
- mem_read_en  output  1  issue a read to main memory this cycle.
- memory_address  output  ADDR_W  read address issued to main memory.
- write_data_array  output  1  write enable for the cache data array.
- data_word_sel  output  3  word index within the block for the data-array write.
- write_data  output  DATA_W  data to write; equals memory_data.
- write_tag_array  output  1  write enable for tag/valid; asserted with the final word.

Behaviour:
- States: IDLE, FILL. Two 4-bit counters: issue_cnt (0..WORDS_PER_BLOCK) and recv_cnt (0..WORDS_PER_BLOCK-1). One base register, base_addr[ADDR_W-1:0].
- Reset (rst high at an edge):
  - state=IDLE, both counters=0, base_addr=0.
  - Every output is 0 from the next cycle onward, since all outputs are derived from state.
  - Reset mid-FILL aborts the fill: no tag write occurs.
  - Main memory must be reset together with this block so no stale valids return.
- IDLE:
  - All outputs 0.
  - memory_data_valid is ignored.
  - On an edge with miss_detected=1: base_addr <= {miss_address[15:4], 4'b0000}; counters <= 0; state <= FILL.
- FILL, issue side (one address per cycle, no bubbles):
  - mem_read_en = (issue_cnt < WORDS_PER_BLOCK).
  - memory_address = base_addr + 2*issue_cnt.
  - issue_cnt increments each cycle while below WORDS_PER_BLOCK, then holds.
  - When mem_read_en=0, memory_address = base_addr (don't-care, held stable).
- FILL, receive side (combinational outputs, same cycle as valid):
  - write_data_array = memory_data_valid.
  - data_word_sel = recv_cnt[2:0].
  - write_data = memory_data.
  - On each valid, recv_cnt increments.
- Completion:
  - When valid arrives with recv_cnt == WORDS_PER_BLOCK-1: write_tag_array=1 in that same cycle, and state <= IDLE.
  - fsm_busy drops the following cycle.
- fsm_busy = (state == FILL). It never drops with words outstanding.
- Latency independence: the FSM counts valids and does not count cycles. With memory latency L and a miss sampled at edge 0:
  - Issues occur in cycles 1..8.
  - Valids arrive in cycles L+1..L+8.
  - Tag write occurs in cycle L+8; fsm_busy is low again from cycle L+9.
  - With L=4, busy lasts 12 cycles.
- Boundary rules:
  - miss_detected during FILL is ignored; the cache re-asserts it after the stall.
  - A miss in the same cycle as the completing valid is ignored. IDLE must see it on a later edge.
  - An unaligned or odd miss_address is masked to the block base.
  - base_addr near 0xFFF0: issued addresses wrap mod 2^16 and never carry into bit 4 of the base. The maximum is base+14.
  - A valid arriving when issue_cnt == recv_cnt cannot occur. If it does, it is still written (no check).

Decomposition:
- Shared package cache_pkg holds:
  - Localparam BLOCK_OFFSET_BITS=4.
  - WORDS_PER_BLOCK default.
  - State encoding typedef fill_state_t {IDLE=1'b0, FILL=1'b1}.
  - Also used by the cache tag/data array blocks.
- One natural sub-module: fill_counter, a 4-bit counter with synchronous clear, increment enable and saturate-at-limit. It is instantiated twice (issue, receive).
- The address add reuses full_adder_16bit: A=base_addr, B={issue_cnt,1'b0}.

Test Plan:
- Basic fill, L=4, miss_address=0x1236:
  - Addresses 0x1230, 0x1232 … 0x123E are issued in cycles 1..8.
  - data_word_sel 0..7 occurs in cycles 5..12.
  - write_tag_array occurs only in cycle 12.
  - fsm_busy is high for cycles 1..12.
- Wrap boundary, miss_address=0xFFFF: addresses 0xFFF0..0xFFFE, with no wrap into 0x0000.
- Miss during fill:
  - Hold miss_detected=1 with address 0x4000 through the 0x1230 fill.
  - The second fill starts only after fsm_busy=0; the first fill's addresses are unaffected.
- Reset mid-fill: assert rst in cycle 6 of a fill.
  - Next cycle: all outputs 0 and no tag write.
  - A fresh miss at 0x2000 then completes normally.
- Latency sweep, L=1 and L=7: busy lasts 9 and 15 cycles respectively. data_word_sel order is 0..7 and write_data matches memory contents.
- Idle noise: memory_data_valid toggling while IDLE produces no write_data_array and no state change.
